// File: rtl/zx_buf_pkg.sv
// Shared constants and helpers for the z/x result buffer.
package zx_buf_pkg;

  localparam int DEF_DATAWIDTH = 32;
  localparam int DEF_DEPTH     = 8;
  localparam int SUM_W         = DEF_DATAWIDTH + 4;
  localparam int DROP_W        = 8;

  // Occupancy needs one extra bit so that DEPTH itself is representable.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/zx_result_buffer_if.sv
// Producer/consumer bundle for zx_result_buffer; slave is the buffer side.
interface zx_result_buffer_if
  import zx_buf_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int DEPTH     = DEF_DEPTH
);

  localparam int CW = cnt_w(DEPTH);

  logic                   InValid;
  logic [DATAWIDTH-1:0]   Z;
  logic [DATAWIDTH-1:0]   X;
  logic                   InReady;
  logic                   Clear;
  logic                   OutValid;
  logic                   OutReady;
  logic [DATAWIDTH-1:0]   OutZ;
  logic [DATAWIDTH-1:0]   OutX;
  logic [CW-1:0]          Count;
  logic                   Overflow;
  logic [DATAWIDTH+3:0]   Sum;
  logic [DROP_W-1:0]      DropCount;

  modport master (
    output InValid, Z, X, Clear, OutReady,
    input  InReady, OutValid, OutZ, OutX, Count, Overflow, Sum, DropCount
  );

  modport slave (
    input  InValid, Z, X, Clear, OutReady,
    output InReady, OutValid, OutZ, OutX, Count, Overflow, Sum, DropCount
  );

endinterface

// File: rtl/zx_buf_mem.sv
// Pair storage: one synchronous write port, one asynchronous read port, no reset.
module zx_buf_mem #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic                     Clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge Clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/zx_result_buffer.sv
// FIFO capture stage for z/x result pairs with occupancy and sticky overflow.
// Optional statistics (Sum, DropCount) are built only when ZX_BUF_STATS_EN is defined.
module zx_result_buffer
  import zx_buf_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int DEPTH     = DEF_DEPTH
) (
  input logic               Clk,
  input logic               Rst,
  zx_result_buffer_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam int SW = DATAWIDTH + 4;

  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic                   in_ready, out_valid;
  logic                   push, pop, drop;
  logic [2*DATAWIDTH-1:0] rd_data;

  // Flags come from registered count only, so OutReady never reaches InReady.
  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);

  assign push = bus.InValid && in_ready  && !bus.Clear;
  assign pop  = out_valid   && bus.OutReady && !bus.Clear;
  assign drop = bus.InValid && !in_ready && !bus.Clear;

  zx_buf_mem #(
    .WIDTH (2*DATAWIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .Clk   (Clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata ({bus.Z, bus.X}),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (bus.Clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (drop) overflow_d = 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.InReady  = in_ready;
  assign bus.OutValid = out_valid;
  assign bus.OutZ     = out_valid ? rd_data[2*DATAWIDTH-1:DATAWIDTH] : '0;
  assign bus.OutX     = out_valid ? rd_data[DATAWIDTH-1:0]           : '0;
  assign bus.Count    = count_q;
  assign bus.Overflow = overflow_q;

`ifdef ZX_BUF_STATS_EN
  logic [SW-1:0]     sum_q, sum_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    sum_d      = sum_q;
    drop_cnt_d = drop_cnt_q;
    if (bus.Clear) begin
      sum_d      = '0;
      drop_cnt_d = '0;
    end else begin
      if (push) sum_d = sum_q + SW'(bus.Z) + SW'(bus.X);
      if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + DROP_W'(1);
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      sum_q      <= '0;
      drop_cnt_q <= '0;
    end else begin
      sum_q      <= sum_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign bus.Sum       = sum_q;
  assign bus.DropCount = drop_cnt_q;
`else
  assign bus.Sum       = '0;
  assign bus.DropCount = '0;
`endif

endmodule

// File: tb/tb_zx_result_buffer.sv
// Randomized and directed bench for zx_result_buffer against a queue-based reference model.
module tb_zx_result_buffer;
  import zx_buf_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 8;

  typedef struct {
    logic [DW-1:0] z;
    logic [DW-1:0] x;
  } pair_t;

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  zx_result_buffer_if #(.DATAWIDTH(DW), .DEPTH(DEPTH)) bus ();

  zx_result_buffer #(.DATAWIDTH(DW), .DEPTH(DEPTH)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  pair_t         mq[$];
  bit            m_ovf;
  logic [DW+3:0] m_sum;
  int            m_drop;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf  = 1'b0;
    m_sum  = '0;
    m_drop = 0;
  endtask

  task automatic check_outputs();
    logic [DW-1:0] ez, ex;
    ez = (mq.size() > 0) ? mq[0].z : '0;
    ex = (mq.size() > 0) ? mq[0].x : '0;
    chk("count",     64'(bus.Count),    64'(mq.size()));
    chk("in_ready",  64'(bus.InReady),  64'(mq.size() != DEPTH));
    chk("out_valid", 64'(bus.OutValid), 64'(mq.size() != 0));
    chk("out_z",     64'(bus.OutZ),     64'(ez));
    chk("out_x",     64'(bus.OutX),     64'(ex));
    chk("overflow",  64'(bus.Overflow), 64'(m_ovf));
`ifdef ZX_BUF_STATS_EN
    chk("sum",       64'(bus.Sum),       64'(m_sum));
    chk("drop_cnt",  64'(bus.DropCount), 64'(m_drop));
`else
    chk("sum",       64'(bus.Sum),       64'(0));
    chk("drop_cnt",  64'(bus.DropCount), 64'(0));
`endif
  endtask

  // Drive one cycle: inputs set just after an edge, outputs checked on the
  // falling edge, model advanced on the rising edge.
  task automatic step(input bit iv, input logic [DW-1:0] z, input logic [DW-1:0] x,
                      input bit ordy, input bit clr);
    bit full, do_pop;
    pair_t p;
    bus.InValid  = iv;
    bus.Z        = z;
    bus.X        = x;
    bus.OutReady = ordy;
    bus.Clear    = clr;
    @(negedge Clk);
    check_outputs();
    @(posedge Clk);
    if (clr) begin
      model_reset();
    end else begin
      full   = (mq.size() == DEPTH);
      do_pop = (mq.size() > 0) && ordy;
      if (do_pop) void'(mq.pop_front());
      if (iv && !full) begin
        p.z = z;
        p.x = x;
        mq.push_back(p);
        m_sum = m_sum + (DW+4)'(z) + (DW+4)'(x);
      end
      if (iv && full) begin
        m_ovf = 1'b1;
        if (m_drop < 255) m_drop++;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, 0, 0);
  endtask

  initial begin
    bus.InValid  = 0;
    bus.Z        = '0;
    bus.X        = '0;
    bus.OutReady = 0;
    bus.Clear    = 0;
    Rst = 1'b1;
    model_reset();
    #3;
    check_outputs();
    #4;
    Rst = 1'b0;
    @(posedge Clk);
    #1;

    // single push, held while stalled, then popped
    step(1, 32'd5, 32'd10, 0, 0);
    idle(3);
    step(0, '0, '0, 1, 0);
    idle(1);

    // fill, drop one, drain in order
    for (int i = 0; i < 8; i++) step(1, 32'(i), 32'(2*i), 0, 0);
    step(1, 32'd99, 32'd98, 0, 0);
    for (int i = 0; i < 8; i++) step(0, '0, '0, 1, 0);
    idle(1);
    step(0, '0, '0, 0, 1);

    // steady-state streaming at occupancy 3
    for (int i = 0; i < 3; i++) step(1, 32'(100 + i), 32'(200 + i), 0, 0);
    for (int i = 3; i < 23; i++) step(1, 32'(100 + i), 32'(200 + i), 1, 0);
    idle(1);
    step(0, '0, '0, 0, 1);

    // full with simultaneous push and pop
    for (int i = 0; i < 8; i++) step(1, 32'(300 + i), 32'(400 + i), 0, 0);
    step(1, 32'hAAAA, 32'hBBBB, 1, 0);
    idle(1);
    step(0, '0, '0, 0, 1);

    // clear beats a same-cycle push and pop
    for (int i = 0; i < 4; i++) step(1, 32'(500 + i), 32'(600 + i), 0, 0);
    step(1, 32'h1234, 32'h5678, 1, 1);
    idle(1);

    // sum carry into the extension bits
    step(1, 32'hFFFF_FFFF, 32'd1, 0, 0);
    step(1, 32'd2, 32'd3, 0, 0);
    idle(1);
`ifdef ZX_BUF_STATS_EN
    chk("sum_carry", 64'(bus.Sum), 64'h1_0000_0005);
`endif

    // asynchronous reset in the middle of traffic
    step(1, 32'h77, 32'h88, 0, 0);
    #2;
    Rst = 1'b1;
    bus.InValid = 0;
    bus.OutReady = 0;
    bus.Clear = 0;
    #1;
    model_reset();
    check_outputs();
    @(negedge Clk);
    Rst = 1'b0;
    @(posedge Clk);
    #1;
    step(1, 32'h11, 32'h22, 0, 0);
    idle(1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom, $urandom,
           $urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0);
    end
    idle(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/zx_result_buffer.md
# zx_result_buffer

Downstream capture stage for the registered `z`/`x` result pair of the two-output arithmetic datapath. It buffers result pairs in a small FIFO and presents them to the consumer over a valid/ready handshake. It tracks occupancy and flags any results lost while full. It decouples the datapath, which produces one pair per cycle, from a consumer that may stall.

## Interface
Parameters:
- `DATAWIDTH`, 32: width of each of `Z`, `X`, `OutZ`, `OutX`.
- `DEPTH`, 8: number of pair entries. Must be a power of two, ≥ 2.

Ports:
- `Clk`  in  1  single clock; all state updates on the rising edge.
- `Rst`  in  1  asynchronous, active-high reset.
- `InValid`  in  1  a `Z`/`X` pair is presented this cycle.
- `Z`  in  DATAWIDTH  `z` result from the datapath.
- `X`  in  DATAWIDTH  `x` result from the datapath.
- `InReady`  out  1  buffer not full.
- `Clear`  in  1  synchronous flush.
- `OutValid`  out  1  head entry available.
- `OutReady`  in  1  consumer accepts the head entry.
- `OutZ`  out  DATAWIDTH  head `z`.
- `OutX`  out  DATAWIDTH  head `x`.
- `Count`  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH.
- `Overflow`  out  1  sticky flag; at least one pair was dropped.
- `Sum`  out  DATAWIDTH+4  stats only; see Configuration.
- `DropCount`  out  8  stats only; see Configuration.

## Operation
- Push: occurs when `InValid && InReady`. The pair is written at `wr_ptr`, and `wr_ptr` increments modulo DEPTH.
- Pop: occurs when `OutValid && OutReady`. `rd_ptr` increments modulo DEPTH.
- Flags: `InReady = (Count != DEPTH)`, `OutValid = (Count != 0)`. Both derive from registered `Count` only; there is no combinational path from `OutReady` to `InReady`.
- Dropped pair: `InValid` while full drops the pair and sets `Overflow`. `Overflow` stays set until `Rst` or `Clear`.
- Simultaneous push and pop with 0 < `Count` < DEPTH: both occur, and `Count` is unchanged.
- Simultaneous push and pop when full: pop occurs, push is refused and dropped, `Overflow` sets, and `Count` becomes DEPTH-1.
- When empty: no bypass. A pushed pair first appears on the output the following cycle.
- Head outputs: `OutZ`/`OutX` = memory[`rd_ptr`] when `OutValid`, otherwise 0. They are held stable while `OutValid && !OutReady`.
- `Clear`: zeroes pointers, `Count`, `Overflow` and stats. It has priority over a same-cycle push or pop; neither takes effect.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. Full and empty are distinguished by `Count`, never by pointer compare.

## Timing
- Reset values (async, immediate on `Rst` assertion): `Count` = 0, `InReady` = 1, `OutValid` = 0, `OutZ`/`OutX` = 0, `Overflow` = 0, `Sum` = 0, `DropCount` = 0, pointers = 0. Memory contents are not reset.
- Latency: a push in cycle N makes `OutValid` = 1 with that data in cycle N+1.
- Throughput: one push and one pop per cycle sustained.
- Reset mid-operation: all queued pairs are discarded. The first edge after deassertion behaves as from empty.

## Configuration
- `ZX_BUF_STATS_EN` defined:
  - `Sum` accumulates `Z + X` (each zero-extended to DATAWIDTH+4) on every accepted push, wrapping modulo 2^(DATAWIDTH+4).
  - `DropCount` increments on every dropped pair and saturates at 255.
  - Both are cleared by `Rst` and `Clear`.
- `ZX_BUF_STATS_EN` undefined: `Sum`, `DropCount` and their logic are absent. All other behaviour is identical.

## Structure
- Shared package `zx_buf_pkg`:
  - default `DATAWIDTH` and `DEPTH`;
  - count-width constant function;
  - `SUM_W` = DATAWIDTH+4 and `DROP_W` = 8.
- Sub-module `zx_buf_mem`: DEPTH × (2·DATAWIDTH) register array with one synchronous write port and one asynchronous read port.
- Top level: pointers, count, flags and stats.

## Test plan
- Reset, then push `Z`=5, `X`=10 with `OutReady`=0 → next cycle `OutValid`=1, `OutZ`=5, `OutX`=10, `Count`=1; outputs held until pop.
- Push 8 pairs (`Z`=i, `X`=2i, i = 0..7) with no pop → `Count`=8, `InReady`=0.
  - Then a 9th push → dropped, `Overflow`=1, `DropCount`=1.
  - Then drain → pairs emerge in order 0..7 and `Count` returns to 0.
- Continuous push and pop for 20 cycles from `Count`=3 → `Count` stays 3; the output sequence equals the input sequence delayed by 3 entries; pointers wrap cleanly.
- Full, with push and pop in the same cycle → `Count`=7, `Overflow`=1, the head advances by one entry.
- `Clear` asserted with `InValid`=1 and `OutReady`=1 at `Count`=4 → next cycle `Count`=0, `Overflow`=0, `OutValid`=0, `Sum`=0.
- Stats build: push (`Z`=0xFFFFFFFF, `X`=1) then (`Z`=2, `X`=3) → `Sum`=0x100000005. Assert `Rst` mid-stream → all outputs immediately return to their reset values.
